// File: rtl/balance_seq.sv
// Power-up and rider sequencer for the balance controller.
// Decides when balance control is powered, when the PID integrator is held,
// and when steering is allowed; withdraws steering on rider imbalance or
// over-speed and defers power-down until the rider has stepped off.
module balance_seq #(
   parameter bit          fast_sim     = 1'b0,
   parameter logic [11:0] MIN_RIDER_WT = 12'h200,
   parameter logic [11:0] WT_HYST      = 12'h040
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic        stop,
   input  logic [11:0] lft_ld,
   input  logic [11:0] rght_ld,
   input  logic        too_fast,
   output logic        pwr_up,
   output logic        rider_off,
   output logic        en_steer,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      ARMED       = 3'd1,
      WAIT_STEADY = 3'd2,
      STEER       = 3'd3
   } state_t;

   // Steady period: LIM+1 consecutive qualified cycles before steering.
   localparam logic [25:0] LIM = fast_sim ? 26'h000_7FFF : 26'h3FF_FFFF;

   // Rider thresholds, widened to the summed-load width before the add/subtract.
   localparam logic [12:0] SET_THR = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
   localparam logic [12:0] CLR_THR = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

   state_t      state_reg, state_next;
   logic        rdr_reg, rdr_next;
   logic [25:0] tmr_reg, tmr_next;
   logic        stop_pend_reg, stop_pend_next;

   logic [12:0] sum;
   logic [11:0] diff;
   logic [13:0] diff_x4;
   logic        balanced;
   logic        qualified;
   logic        tmr_at_lim;

   // Load arithmetic: balanced when the imbalance is under a quarter of the total.
   always_comb begin
      sum     = {1'b0, lft_ld} + {1'b0, rght_ld};
      diff    = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
      diff_x4 = {diff, 2'b00};
      balanced   = (diff_x4 < {1'b0, sum});
      qualified  = balanced & ~too_fast;
      tmr_at_lim = (tmr_reg == LIM);
   end

   // Rider-present flag with hysteresis band; holds between thresholds.
   always_comb begin
      rdr_next = rdr_reg;
      if (sum > SET_THR) begin
         rdr_next = 1'b1;
      end else if (sum < CLR_THR) begin
         rdr_next = 1'b0;
      end
   end

   // Next-state logic and state-decoded outputs (outputs depend on state only).
   always_comb begin
      state_next = state_reg;
      pwr_up     = 1'b0;
      rider_off  = 1'b1;
      en_steer   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (go && !stop) begin
               state_next = ARMED;
            end
         end
         ARMED: begin
            pwr_up = 1'b1;
            // A pending stop only powers down once the rider is off.
            if ((stop || stop_pend_reg) && !rdr_reg) begin
               state_next = IDLE;
            end else if (rdr_reg) begin
               state_next = WAIT_STEADY;
            end
         end
         WAIT_STEADY: begin
            pwr_up    = 1'b1;
            rider_off = 1'b0;
            // Rider leaving beats a completed steady period.
            if (!rdr_reg) begin
               state_next = ARMED;
            end else if (qualified && tmr_at_lim) begin
               state_next = STEER;
            end
         end
         STEER: begin
            pwr_up    = 1'b1;
            rider_off = 1'b0;
            en_steer  = 1'b1;
            if (!rdr_reg) begin
               state_next = ARMED;
            end else if (!qualified) begin
               state_next = WAIT_STEADY;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Steady timer counts only unbroken qualified WAIT_STEADY cycles, saturating at LIM.
   always_comb begin
      tmr_next = '0;
      if (state_reg == WAIT_STEADY && qualified) begin
         tmr_next = tmr_at_lim ? tmr_reg : tmr_reg + 26'd1;
      end
   end

   // Stop latch remembers a stop request until the sequencer is back in IDLE.
   always_comb begin
      stop_pend_next = stop_pend_reg;
      if (state_next == IDLE) begin
         stop_pend_next = 1'b0;
      end else if (stop && state_reg != IDLE) begin
         stop_pend_next = 1'b1;
      end
   end

   // State, rider flag, timer and stop latch registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         rdr_reg       <= 1'b0;
         tmr_reg       <= '0;
         stop_pend_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         rdr_reg       <= rdr_next;
         tmr_reg       <= tmr_next;
         stop_pend_reg <= stop_pend_next;
      end
   end

   assign state = state_reg;

endmodule
